spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI peripheral (slave) endpoint, the far end of the team's SPI master.
- Oversamples SCK, CS_n and MOSI in the i_Clk domain.
- Shifts a byte in on MOSI and a byte out on MISO per 8 SCK cycles.
- Hands bytes to and from fabric logic through a single-byte TX holding register and a one-cycle RX valid pulse.
- Used where the design is controlled by an external SPI host (e.g. config/register access).

Parameters:
SPI_MODE, 0, SPI mode 0-3. CPOL = mode 2 or 3; CPHA = mode 1 or 3.
SYNC_STAGES, 2, flops in each input synchroniser; must be >= 2.
DEFAULT_TX, 8'hFF, byte shifted out when no TX byte is pending (underrun).

Ports:
i_Clk  input  1  system clock; must be >= 8x SCK frequency.
i_Rst_L  input  1  reset, asynchronous, active-low.
i_TX_Byte  input  8  byte to return to the host on MISO.
i_TX_DV  input  1  one-cycle strobe; writes i_TX_Byte into the holding register.
o_TX_Ready  output  1  holding register empty; i_TX_DV accepted.
o_RX_DV  output  1  one-cycle pulse; o_RX_Byte is valid.
o_RX_Byte  output  8  last complete byte received (MSb first).
o_TX_Underrun  output  1  one-cycle pulse when DEFAULT_TX is loaded because the holding register was empty.
i_SPI_Clk  input  1  SCK from the host (asynchronous).
i_SPI_CS_n  input  1  chip select, active-low (asynchronous).
i_SPI_MOSI  input  1  serial data in.
o_SPI_MISO  output  1  serial data out.
o_SPI_MISO_En  output  1  MISO tristate enable; equals synchronised CS active.

Behaviour:
- Reset values: o_RX_DV 0, o_RX_Byte 8'h00, o_TX_Ready 1, o_TX_Underrun 0, o_SPI_MISO 0, o_SPI_MISO_En 0; holding empty; bit counter 7; state IDLE.
- Synchronisation:
  - SCK, CS_n and MOSI each pass through SYNC_STAGES flops.
  - Edge detect compares the last synchronised stage against one further flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- Sampling edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- State machine:
  - IDLE -> ACTIVE on synchronised CS falling edge.
  - ACTIVE -> IDLE on synchronised CS rising edge.
  - SCK edges are ignored in IDLE.
- Load event (shift register <= holding, or DEFAULT_TX if empty):
  - CS falling edge.
  - Each 8th sampling edge while ACTIVE.
  - Load empties the holding register: o_TX_Ready goes 1 the next cycle.
  - Loading DEFAULT_TX pulses o_TX_Underrun.
- MISO drive:
  - CPHA=0: MSb driven on the load cycle; each trailing edge drives the next bit. The trailing edge after the 8th sample is replaced by the load.
  - CPHA=1: each leading edge drives the next bit, starting with the MSb.
  - The host must allow >= SYNC_STAGES+3 i_Clk from CS falling to the first SCK edge.
- RX path:
  - Each sampling edge shifts synchronised MOSI into the RX shift register.
  - On the 8th edge, o_RX_Byte <= assembled byte and o_RX_DV=1 for exactly 1 cycle.
  - Latency: <= SYNC_STAGES+2 i_Clk after the 8th pin-level sampling edge.
  - Bit counter wraps 0 -> 7, giving unbounded back-to-back bytes within one CS assertion.
- Holding register:
  - i_TX_DV with o_TX_Ready=1 captures the byte; o_TX_Ready goes 0 the next cycle.
  - i_TX_DV with o_TX_Ready=0 is ignored; the holding byte is unchanged.
  - i_TX_DV in the same cycle as a load: the load uses the pre-cycle holding content and the new byte fills the holding register. o_TX_Ready is then 0.
- CS rising mid-byte:
  - Partial RX byte is discarded; no o_RX_DV.
  - Bit counter returns to 7.
  - A held TX byte remains held for the next transaction.
  - o_SPI_MISO_En drops the cycle after detection.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); the holding byte is lost.

Decomposition:
- Package spi_pkg:
  - typedef enum {IDLE, ACTIVE} spi_slv_state_t.
  - Functions cpol(mode) and cpha(mode).
  - Localparam BITS_PER_BYTE = 8.
- Sub-module spi_sync_edge: parameterised N-stage synchroniser with rise/fall pulse outputs. Instantiated for SCK, CS_n and MOSI (MOSI uses level only).

Test Plan:
- Mode 0, SCK = i_Clk/8, preload TX 8'h3C, host sends 8'hA5 -> o_RX_DV once with o_RX_Byte=8'hA5; host receives 8'h3C; o_TX_Ready rises after CS falling.
- Mode 3, one CS, host sends 8'h12, 8'h34, with 8'h56 then 8'h78 written at each o_TX_Ready -> RX pulses 8'h12, 8'h34; host receives 8'h56, 8'h78.
- No TX preload, modes 1 and 2, host sends 8'h00 -> host receives 8'hFF; o_TX_Underrun pulses once per byte.
- CS deasserted after 5 SCK cycles, then a new full byte 8'hC3 -> no RX_DV for the partial byte; next o_RX_Byte=8'hC3 with correct alignment.
- i_TX_DV with 8'hAA while o_TX_Ready=0 (holding 8'h55) -> host receives 8'h55; 8'hAA never appears.
- i_Rst_L low after 4 bits -> all outputs at reset values; after release, a full byte 8'h0F is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI peripheral endpoint.
package spi_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic {IDLE, ACTIVE} spi_slv_state_t;

    function automatic logic cpol(input int unsigned mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic cpha(input int unsigned mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = sync_q[STAGES-1] & ~prev_q;
    assign o_fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversampled SCK/CS_n/MOSI, byte-wide RX pulse and TX holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE    = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_TX_Underrun,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic       CPOL     = cpol(SPI_MODE);
    localparam logic       CPHA     = cpha(SPI_MODE);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_async (i_SPI_Clk),
        .o_level (sck_level_unused),
        .o_rise  (sck_rise),
        .o_fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_async (i_SPI_CS_n),
        .o_level (cs_level_unused),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_async (i_SPI_MOSI),
        .o_level (mosi),
        .o_rise  (mosi_rise_unused),
        .o_fall  (mosi_fall_unused)
    );

    spi_slv_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     rx_shift_q, rx_shift_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_dv_q, rx_dv_d;
    logic [7:0]     tx_shift_q, tx_shift_d;
    logic           miso_q, miso_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic           underrun_q, underrun_d;

    logic       leading, trailing, sample_edge, shift_edge, load;
    logic [7:0] load_byte;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_dv_d      = 1'b0;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        underrun_d   = 1'b0;
        load         = 1'b0;
        load_byte    = DEFAULT_TX;

        leading     = CPOL ? sck_fall : sck_rise;
        trailing    = CPOL ? sck_rise : sck_fall;
        sample_edge = CPHA ? trailing : leading;
        shift_edge  = CPHA ? leading : trailing;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = LAST_BIT;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = LAST_BIT;
                    rx_shift_d = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi};
                    if (bit_cnt_q == 3'd0) begin
                        rx_byte_d = {rx_shift_q, mosi};
                        rx_dv_d   = 1'b1;
                        bit_cnt_d = LAST_BIT;
                        load      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                // In CPHA=0 the shift right after a byte boundary is replaced by the load.
                end else if (shift_edge && (CPHA || bit_cnt_q != LAST_BIT)) begin
                    miso_d     = CPHA ? tx_shift_q[7] : tx_shift_q[6];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            load_byte    = hold_valid_q ? hold_q : DEFAULT_TX;
            tx_shift_d   = load_byte;
            underrun_d   = ~hold_valid_q;
            hold_valid_d = 1'b0;
            if (!CPHA) begin
                miso_d = load_byte[7];
            end
        end

        if (i_TX_DV && !hold_valid_q) begin
            hold_d       = i_TX_Byte;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= IDLE;
            bit_cnt_q    <= LAST_BIT;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_dv_q      <= 1'b0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_TX_Ready    = ~hold_valid_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_TX_Underrun = underrun_q;
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_En = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: one spi_slave per SPI mode, driven by a simple host model at SCK = i_Clk/8.
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic [3:0] tx_dv;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic       mosi;
    logic [3:0] tx_ready, rx_dv, underrun, miso, miso_en;
    logic [7:0] rx_byte [4];

    int checks = 0;
    int errors = 0;

    int         rx_cnt [4];
    int         ur_cnt [4];
    logic [7:0] rx_last[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) u_dut (
            .i_Clk         (clk),
            .i_Rst_L       (rst_n),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (tx_dv[g]),
            .o_TX_Ready    (tx_ready[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .o_TX_Underrun (underrun[g]),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_En (miso_en[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_dv[k] === 1'b1) begin
                rx_cnt[k]  <= rx_cnt[k] + 1;
                rx_last[k] <= rx_byte[k];
            end
            if (underrun[k] === 1'b1) begin
                ur_cnt[k] <= ur_cnt[k] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_write(input int m, input logic [7:0] b);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high(input int m);
        cs_n[m] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Host side of one (possibly partial) byte, MSb first; returns what was seen on MISO.
    task automatic xfer(input int m, input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        logic p;
        logic h;
        p  = (m >= 2);
        h  = (m % 2 == 1);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!h) begin
                mosi   = tx[i];
                half();
                rx[i]  = miso[m];
                sck[m] = ~p;
                half();
                sck[m] = p;
            end else begin
                half();
                sck[m] = ~p;
                mosi   = tx[i];
                half();
                rx[i]  = miso[m];
                sck[m] = p;
            end
        end
        half();
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] rx;

    initial begin
        rst_n   = 1'b0;
        tx_byte = '0;
        tx_dv   = '0;
        sck     = 4'b1100;
        cs_n    = 4'b1111;
        mosi    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rx_dv", rx_dv[0], 1'b0);
        check("rst_rx_byte", rx_byte[0], 8'h00);
        check("rst_tx_ready", tx_ready[0], 1'b1);
        check("rst_underrun", underrun[0], 1'b0);
        check("rst_miso", miso[0], 1'b0);
        check("rst_miso_en", miso_en[0], 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0: preload 3C, host sends A5
        tx_write(0, 8'h3C);
        check("m0_ready_after_write", tx_ready[0], 1'b0);
        cs_low(0);
        check("m0_miso_en", miso_en[0], 1'b1);
        check("m0_ready_after_cs", tx_ready[0], 1'b1);
        check("m0_no_underrun_cs", ur_cnt[0], 0);
        xfer(0, 8'hA5, 8, rx);
        check("m0_host_rx", rx, 8'h3C);
        check("m0_rx_cnt", rx_cnt[0], 1);
        check("m0_rx_byte", rx_last[0], 8'hA5);
        check("m0_underrun_end", ur_cnt[0], 1);
        cs_high(0);
        check("m0_miso_en_off", miso_en[0], 1'b0);

        // Mode 3: two bytes in one CS, TX written at each ready
        tx_write(3, 8'h56);
        cs_low(3);
        check("m3_ready_cs", tx_ready[3], 1'b1);
        tx_write(3, 8'h78);
        check("m3_ready_full", tx_ready[3], 1'b0);
        xfer(3, 8'h12, 8, rx);
        check("m3_host_rx0", rx, 8'h56);
        check("m3_rx_cnt0", rx_cnt[3], 1);
        check("m3_rx_byte0", rx_last[3], 8'h12);
        check("m3_ready_reload", tx_ready[3], 1'b1);
        xfer(3, 8'h34, 8, rx);
        check("m3_host_rx1", rx, 8'h78);
        check("m3_rx_cnt1", rx_cnt[3], 2);
        check("m3_rx_byte1", rx_last[3], 8'h34);
        check("m3_underrun", ur_cnt[3], 1);
        cs_high(3);

        // Modes 1 and 2: underrun returns DEFAULT_TX
        for (int m = 1; m <= 2; m++) begin
            cs_low(m);
            check("ur_cs_load", ur_cnt[m], 1);
            xfer(m, 8'h00, 8, rx);
            check("ur_host_rx", rx, 8'hFF);
            check("ur_byte_end", ur_cnt[m], 2);
            check("ur_rx_byte", rx_last[m], 8'h00);
            check("ur_rx_cnt", rx_cnt[m], 1);
            cs_high(m);
        end

        // Mode 0: CS rises after 5 bits, then a full C3
        cs_low(0);
        xfer(0, 8'hF0, 5, rx);
        cs_high(0);
        check("abort_no_rx_dv", rx_cnt[0], 1);
        check("abort_miso_en", miso_en[0], 1'b0);
        cs_low(0);
        xfer(0, 8'hC3, 8, rx);
        check("abort_next_cnt", rx_cnt[0], 2);
        check("abort_next_byte", rx_last[0], 8'hC3);
        cs_high(0);

        // Mode 0: write while holding is full is ignored
        tx_write(0, 8'h55);
        check("hold_ready0", tx_ready[0], 1'b0);
        tx_write(0, 8'hAA);
        check("hold_ready_still0", tx_ready[0], 1'b0);
        cs_low(0);
        xfer(0, 8'h00, 8, rx);
        check("hold_host_rx", rx, 8'h55);
        check("hold_ready_empty", tx_ready[0], 1'b1);
        cs_high(0);
        cs_low(0);
        xfer(0, 8'h00, 8, rx);
        check("hold_no_aa", rx, 8'hFF);
        cs_high(0);

        // Mode 0: reset after 4 bits, then 0F
        cs_low(0);
        tx_write(0, 8'h99);
        xfer(0, 8'hFF, 4, rx);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rx_dv", rx_dv[0], 1'b0);
        check("mid_rst_rx_byte", rx_byte[0], 8'h00);
        check("mid_rst_tx_ready", tx_ready[0], 1'b1);
        check("mid_rst_underrun", underrun[0], 1'b0);
        check("mid_rst_miso", miso[0], 1'b0);
        check("mid_rst_miso_en", miso_en[0], 1'b0);
        cs_n[0] = 1'b1;
        sck[0]  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_en", miso_en[0], 1'b0);
        cs_low(0);
        xfer(0, 8'h0F, 8, rx);
        check("post_rst_cnt", rx_cnt[0], 5);
        check("post_rst_byte", rx_last[0], 8'h0F);
        cs_high(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
